// File: rtl/ram_helper_pkg.sv
// Shared types, parameter legality checks and memory-access helpers for ram_helper_pipe.
// The helpers are backed by a sparse SV memory model held in this package.
package ram_helper_pkg;

    localparam int RESP_ID_MAX_W = 16;

    typedef logic [RESP_ID_MAX_W-1:0] resp_id_t;

    typedef struct packed {
        logic [63:0] rdata;
        resp_id_t    id;
        logic        is_write;
    } resp_t;

    function automatic bit latency_ok(input int latency);
        return (latency >= 1) && (latency <= 16);
    endfunction

    function automatic bit depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    // Words never written read back as zero, matching a freshly initialised RAM.
    logic [63:0] ram_model [logic [63:0]];

    function automatic void init_ram();
        ram_model.delete();
    endfunction

    function automatic logic [63:0] ram_read_helper(input bit r_en, input logic [63:0] r_idx);
        if (r_en && (ram_model.exists(r_idx) != 0)) return ram_model[r_idx];
        return '0;
    endfunction

    function automatic void ram_write_helper(input logic [63:0] w_idx, input logic [63:0] w_data,
                                             input logic [63:0] w_mask, input bit w_en);
        logic [63:0] old_word;
        if (!w_en) return;
        old_word = (ram_model.exists(w_idx) != 0) ? ram_model[w_idx] : '0;
        ram_model[w_idx] = (old_word & ~w_mask) | (w_data & w_mask);
    endfunction

endpackage

// File: rtl/ram_helper_if.sv
// Request/response bus of ram_helper_pipe; resp_is_write exists only with RAM_HELPER_WRITE_RESP_EN.
interface ram_helper_if #(
    parameter int ID_W = 4
) ();

    logic            req_valid;
    logic            req_ready;
    logic            req_wen;
    logic [63:0]     req_idx;
    logic [63:0]     req_wdata;
    logic [63:0]     req_wmask;
    logic [ID_W-1:0] req_id;

    logic            resp_valid;
    logic            resp_ready;
    logic [63:0]     resp_rdata;
    logic [ID_W-1:0] resp_id;
`ifdef RAM_HELPER_WRITE_RESP_EN
    logic            resp_is_write;
`endif

    modport master (
        output req_valid, req_wen, req_idx, req_wdata, req_wmask, req_id, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_id
`ifdef RAM_HELPER_WRITE_RESP_EN
        , input resp_is_write
`endif
    );

    modport slave (
        input  req_valid, req_wen, req_idx, req_wdata, req_wmask, req_id, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_id
`ifdef RAM_HELPER_WRITE_RESP_EN
        , output resp_is_write
`endif
    );

endinterface

// File: rtl/ram_helper_fifo.sv
// In-order show-ahead FIFO holding responses that have left the latency pipeline.
module ram_helper_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    // NOTE: storage is deliberately not reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + (AW+1)'(1);
            if (pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/ram_helper_pipe.sv
// Fixed-latency, credit-limited wrapper around the RAM access helpers.
// Macro RAM_HELPER_WRITE_RESP_EN makes writes return a response and adds resp_is_write.
module ram_helper_pipe
    import ram_helper_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 8,
    parameter int ID_W    = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    ram_helper_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    if (!latency_ok(LATENCY)) begin : g_bad_latency
        $error("ram_helper_pipe: LATENCY must be 1..16");
    end
    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("ram_helper_pipe: DEPTH must be a power of 2, >= 2");
    end
    if (ID_W < 1 || ID_W > RESP_ID_MAX_W) begin : g_bad_id_w
        $error("ram_helper_pipe: ID_W out of range");
    end

    logic [CNT_W-1:0] outstanding;
    logic             accept;
    logic             resp_needed;
    logic             handshake;
    logic             pipe_vld [LATENCY];
    resp_t            pipe_dat [LATENCY];
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_empty;
    logic             fifo_full;
    resp_t            fifo_head;
    resp_t            resp_head;
    logic             unused_bits;
    // Survives rst_n so the RAM is initialised once and keeps its contents across resets.
    logic             ram_inited = 1'b0;

    assign bus.req_ready = (outstanding < CNT_W'(DEPTH));
    assign accept        = bus.req_valid && bus.req_ready;

`ifdef RAM_HELPER_WRITE_RESP_EN
    assign resp_needed = 1'b1;
`else
    assign resp_needed = !bus.req_wen;
`endif

    // NOTE: helper calls execute in statement order within this block (init before first access);
    // every register update is non-blocking so the shift chain moves as one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                pipe_vld[s] <= 1'b0;
                pipe_dat[s] <= '0;
            end
        end else begin
            if (!ram_inited) begin
                init_ram();
                ram_inited <= 1'b1;
            end
            pipe_vld[0] <= accept && resp_needed;
            pipe_dat[0] <= '0;
            if (accept) begin
                pipe_dat[0].id       <= resp_id_t'(bus.req_id);
                pipe_dat[0].is_write <= bus.req_wen;
                if (bus.req_wen) ram_write_helper(bus.req_idx, bus.req_wdata, bus.req_wmask, 1'b1);
                else             pipe_dat[0].rdata <= ram_read_helper(1'b1, bus.req_idx);
            end
            for (int s = 1; s < LATENCY; s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
                pipe_dat[s] <= pipe_dat[s-1];
            end
            outstanding <= outstanding + CNT_W'(accept && resp_needed) - CNT_W'(handshake);
        end
    end

    // The last stage is offered directly when the FIFO is empty; otherwise it queues behind older entries.
    assign fifo_pop  = !fifo_empty && bus.resp_ready;
    assign fifo_push = pipe_vld[LATENCY-1] && !(fifo_empty && bus.resp_ready);

    ram_helper_fifo #(
        .WIDTH ($bits(resp_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (pipe_dat[LATENCY-1]),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign resp_head      = fifo_empty ? pipe_dat[LATENCY-1] : fifo_head;
    assign bus.resp_valid = !fifo_empty || pipe_vld[LATENCY-1];
    assign bus.resp_rdata = resp_head.rdata;
    assign bus.resp_id    = resp_head.id[ID_W-1:0];
    assign handshake      = bus.resp_valid && bus.resp_ready;
`ifdef RAM_HELPER_WRITE_RESP_EN
    assign bus.resp_is_write = resp_head.is_write;
`endif

    assign unused_bits = ^{fifo_full, resp_head.id, resp_head.is_write};

endmodule

// File: tb/tb_ram_helper_pipe.sv
// Directed self-checking bench for ram_helper_pipe (LATENCY=4, DEPTH=8, ID_W=4).
module tb_ram_helper_pipe;

    localparam int LATENCY = 4;
    localparam int DEPTH   = 8;
    localparam int ID_W    = 4;
`ifdef RAM_HELPER_WRITE_RESP_EN
    localparam int EXP_MIX_RESP = 3;
`else
    localparam int EXP_MIX_RESP = 1;
`endif

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    logic [63:0]     q_data [$];
    logic [ID_W-1:0] q_id   [$];
    logic            q_wr   [$];

    ram_helper_if #(.ID_W(ID_W)) bus ();

    ram_helper_pipe #(
        .LATENCY (LATENCY),
        .DEPTH   (DEPTH),
        .ID_W    (ID_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Inputs only change 1ns after a rising edge, so the negedge view equals the next edge's view.
    always @(negedge clk) begin
        if (rst_n && bus.resp_valid && bus.resp_ready) begin
            q_data.push_back(bus.resp_rdata);
            q_id.push_back(bus.resp_id);
`ifdef RAM_HELPER_WRITE_RESP_EN
            q_wr.push_back(bus.resp_is_write);
`else
            q_wr.push_back(1'b0);
`endif
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        q_data.delete();
        q_id.delete();
        q_wr.delete();
    endtask

    task automatic send(input logic wen, input logic [63:0] idx, input logic [63:0] wdata,
                        input logic [63:0] wmask, input logic [ID_W-1:0] id);
        int budget;
        budget        = 100;
        bus.req_valid = 1'b1;
        bus.req_wen   = wen;
        bus.req_idx   = idx;
        bus.req_wdata = wdata;
        bus.req_wmask = wmask;
        bus.req_id    = id;
        while (!bus.req_ready && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (budget == 0) check("send_timeout", 64'(bus.req_ready), 64'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        bus.resp_ready = 1'b1;
        repeat (LATENCY + DEPTH + 4) @(posedge clk);
        #1;
        clear_q();
    endtask

    task automatic wait_resp(input int n);
        int budget;
        budget = 100;
        while (q_id.size() < n && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (q_id.size() < n) check("resp_timeout", 64'(q_id.size()), 64'(n));
    endtask

    initial begin
        int lat;
        int n_acc;
        logic acc_now;

        n_cmp = 0;
        n_bad = 0;
        clk = 1'b0;
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_wen = 1'b0;
        bus.req_idx = '0;
        bus.req_wdata = '0;
        bus.req_wmask = '0;
        bus.req_id = '0;
        bus.resp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_resp_rdata", bus.resp_rdata, 64'd0);
        check("rst_resp_id", 64'(bus.resp_id), 64'd0);
        rst_n = 1'b1;

        // Single read latency and data.
        bus.resp_ready = 1'b1;
        send(1'b1, 64'h10, 64'hDEAD_BEEF, '1, 4'd1);
        drain();
        send(1'b0, 64'h10, '0, '0, 4'd3);
        lat = 1;
        while (!bus.resp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("rd_latency", 64'(lat), 64'(LATENCY));
        check("rd_data", bus.resp_rdata, 64'hDEAD_BEEF);
        check("rd_id", 64'(bus.resp_id), 64'd3);
        drain();

        // Masked write and an untouched word.
        send(1'b1, 64'h5, 64'hFFFF_FFFF_FFFF_FFFF, '1, 4'd0);
        send(1'b1, 64'h5, 64'h0, 64'h0000_0000_FFFF_FFFF, 4'd0);
        drain();
        send(1'b0, 64'h5, '0, '0, 4'd4);
        send(1'b0, 64'h99, '0, '0, 4'd5);
        wait_resp(2);
        check("mask_data", q_data[0], 64'hFFFF_FFFF_0000_0000);
        check("mask_id", 64'(q_id[0]), 64'd4);
        check("blank_data", q_data[1], 64'd0);
        check("blank_id", 64'(q_id[1]), 64'd5);
        drain();

        // Backpressure: 10 reads against 8 credits.
        for (int i = 0; i < 10; i++) send(1'b1, 64'h20 + 64'(i), 64'h1000 + 64'(i), '1, 4'd0);
        drain();
        bus.resp_ready = 1'b0;
        n_acc = 0;
        for (int c = 0; c < 15; c++) begin
            bus.req_valid = (n_acc < 10);
            bus.req_wen   = 1'b0;
            bus.req_idx   = 64'h20 + 64'(n_acc);
            bus.req_id    = ID_W'(n_acc);
            acc_now = bus.req_valid && bus.req_ready;
            @(posedge clk); #1;
            if (acc_now) n_acc++;
        end
        check("bp_accepted", 64'(n_acc), 64'd8);
        check("bp_ready_low", 64'(bus.req_ready), 64'd0);
        check("bp_head_id", 64'(bus.resp_id), 64'd0);
        check("bp_head_data", bus.resp_rdata, 64'h1000);
        repeat (2) @(posedge clk);
        #1;
        check("bp_hold_valid", 64'(bus.resp_valid), 64'd1);
        check("bp_hold_id", 64'(bus.resp_id), 64'd0);

        // Full: a response handshake does not free a credit within the same cycle.
        bus.resp_ready = 1'b1;
        check("full_same_cycle", 64'(bus.req_ready), 64'd0);
        @(posedge clk); #1;
        check("full_after_pop", 64'(bus.req_ready), 64'd1);
        bus.resp_ready = 1'b0;
        acc_now = bus.req_valid && bus.req_ready;
        @(posedge clk); #1;
        if (acc_now) n_acc++;
        check("full_accept_next", 64'(n_acc), 64'd9);
        check("full_again", 64'(bus.req_ready), 64'd0);
        bus.resp_ready = 1'b1;
        for (int c = 0; c < 100 && (n_acc < 10 || q_id.size() < 10); c++) begin
            bus.req_valid = (n_acc < 10);
            bus.req_idx   = 64'h20 + 64'(n_acc);
            bus.req_id    = ID_W'(n_acc);
            acc_now = bus.req_valid && bus.req_ready;
            @(posedge clk); #1;
            if (acc_now) n_acc++;
        end
        bus.req_valid = 1'b0;
        check("bp_resp_count", 64'(q_id.size()), 64'd10);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp_order_id%0d", i), 64'(q_id[i]), 64'(i));
            check($sformatf("bp_order_data%0d", i), q_data[i], 64'h1000 + 64'(i));
        end
        drain();

        // Reset with three reads in flight.
        for (int i = 0; i < 3; i++) begin
            bus.req_valid = 1'b1;
            bus.req_wen   = 1'b0;
            bus.req_idx   = 64'h10;
            bus.req_id    = ID_W'(5 + i);
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(bus.resp_valid), 64'd0);
        check("mid_rst_ready", 64'(bus.req_ready), 64'd1);
        check("mid_rst_rdata", bus.resp_rdata, 64'd0);
        check("mid_rst_id", 64'(bus.resp_id), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("no_stale_resp", 64'(q_id.size()), 64'd0);
        send(1'b0, 64'h5, '0, '0, 4'd2);
        wait_resp(1);
        check("persist_data", q_data[0], 64'hFFFF_FFFF_0000_0000);
        check("persist_id", 64'(q_id[0]), 64'd2);
        drain();

        // Two writes and a read: response count depends on the write-response build.
        send(1'b1, 64'h30, 64'h3333, '1, 4'hA);
        send(1'b1, 64'h31, 64'h4444, '1, 4'hB);
        send(1'b0, 64'h30, '0, '0, 4'hC);
        repeat (20) @(posedge clk);
        #1;
        check("mix_resp_count", 64'(q_id.size()), 64'(EXP_MIX_RESP));
        if (q_id.size() == EXP_MIX_RESP) begin
            check("mix_rd_data", q_data[EXP_MIX_RESP-1], 64'h3333);
            check("mix_rd_id", 64'(q_id[EXP_MIX_RESP-1]), 64'hC);
`ifdef RAM_HELPER_WRITE_RESP_EN
            check("mix_is_write0", 64'(q_wr[0]), 64'd1);
            check("mix_is_write1", 64'(q_wr[1]), 64'd1);
            check("mix_is_write2", 64'(q_wr[2]), 64'd0);
            check("mix_wr_rdata", q_data[0], 64'd0);
            check("mix_wr_id", 64'(q_id[1]), 64'hB);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
